// File: rtl/tsw_time_ctrl.sv
// tsw_time_ctrl
// Front-end control stage for the digital clock. Synchronises and debounces
// the eight TSW switches, runs the RUN/SET mode FSM, generates the
// one-second tick and the minute/hour/seconds-clear strobes used by the
// downstream counter chain.
//
// Ports:
//   pCLK      in   1  clock, all logic on posedge
//   nRST      in   1  asynchronous active-low reset
//   TSW       in   8  raw switches, active-high, asynchronous to pCLK
//   sec_tick  out  1  one-cycle pulse every TICK_DIV cycles while in RUN
//   inc_min   out  1  one-cycle minute-increment strobe (SET only)
//   inc_hour  out  1  one-cycle hour-increment strobe (SET only)
//   sec_clr   out  1  one-cycle seconds-clear strobe (SET only)
//   set_mode  out  1  1 = SET state
//   sw_db     out  8  debounced switch levels
//
// Optional feature: define TSW_AUTOREPEAT_EN to enable auto-repeat of the
// minute/hour keys while held in SET. Without it every press yields exactly
// one strobe.
module tsw_time_ctrl #(
  parameter int TICK_DIV   = 1024,
  parameter int DEB_SH     = 4,
  parameter int REPEAT_DLY = 32,
  parameter int REPEAT_PER = 8
) (
  input  logic       pCLK,
  input  logic       nRST,
  input  logic [7:0] TSW,
  output logic       sec_tick,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       sec_clr,
  output logic       set_mode,
  output logic [7:0] sw_db
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_sync1;
  logic [7:0]        r_sync2;
  logic [DEB_SH-1:0] r_deb_cnt;
  logic              w_samp;
  logic [7:0][2:0]   r_hist;
  logic [7:0][2:0]   w_hist_nxt;
  logic [7:0]        r_sw_db;
  logic [7:0]        w_db_nxt;
  logic [3:0]        r_sw_db_d;
  logic [3:0]        w_rise;
  logic [PW-1:0]     r_presc;
  logic [PW-1:0]     w_presc_nxt;
  logic              r_sec_tick;
  logic              r_inc_min;
  logic              r_inc_hour;
  logic              r_sec_clr;
  logic              w_tick_nxt;
  logic              w_min_nxt;
  logic              w_hour_nxt;
  logic              w_clr_nxt;
  logic              w_rpt_min;
  logic              w_rpt_hour;

  // Sample strobe fires once per 2^DEB_SH cycles, when the counter wraps.
  assign w_samp = &r_deb_cnt;

  // A bit only changes once three consecutive samples (including the one
  // being taken this cycle) agree; the compare against the current level is
  // implicit because an agreeing value equal to sw_db leaves it unchanged.
  always_comb begin
    w_hist_nxt = r_hist;
    w_db_nxt   = r_sw_db;
    for (int i = 0; i < 8; i++) begin
      w_hist_nxt[i] = {r_hist[i][1:0], r_sync2[i]};
      if (w_samp && (w_hist_nxt[i] == 3'b111)) w_db_nxt[i] = 1'b1;
      if (w_samp && (w_hist_nxt[i] == 3'b000)) w_db_nxt[i] = 1'b0;
    end
  end

  assign w_rise = r_sw_db[3:0] & ~r_sw_db_d;

`ifdef TSW_AUTOREPEAT_EN
  logic [7:0] r_rpt_cnt;
  logic [7:0] w_rpt_inc;
  logic       w_rpt_hold;
  logic       w_rpt_fire;

  // Exactly one of the two increment keys held in a stable SET state; a
  // toggle this cycle or both keys down restarts the delay.
  assign w_rpt_hold = (r_state == ST_SET) && !w_rise[0] && (r_sw_db[1] ^ r_sw_db[2]);
  assign w_rpt_inc  = r_rpt_cnt + 8'd1;
  assign w_rpt_fire = w_rpt_hold && w_samp && (w_rpt_inc == 8'(REPEAT_DLY));

  // After a repeat the counter is rewound by REPEAT_PER so the next one
  // lands REPEAT_PER samples later at the same compare value.
  always_ff @(posedge pCLK or negedge nRST) begin
    if (!nRST) begin
      r_rpt_cnt <= '0;
    end else if (!w_rpt_hold) begin
      r_rpt_cnt <= '0;
    end else if (w_samp) begin
      r_rpt_cnt <= w_rpt_fire ? 8'(REPEAT_DLY - REPEAT_PER) : w_rpt_inc;
    end
  end

  assign w_rpt_min  = w_rpt_fire & r_sw_db[1];
  assign w_rpt_hour = w_rpt_fire & r_sw_db[2];
`else
  assign w_rpt_min  = 1'b0;
  assign w_rpt_hour = 1'b0;
`endif

  // Strobes are qualified by the state held before this cycle, so a key
  // pressed together with the mode toggle follows the old mode.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;
    w_min_nxt   = 1'b0;
    w_hour_nxt  = 1'b0;
    w_clr_nxt   = 1'b0;
    if (w_rise[0]) w_state_nxt = (r_state == ST_RUN) ? ST_SET : ST_RUN;
    case (r_state)
      ST_RUN: begin
        if (r_presc == PW'(TICK_DIV - 1)) begin
          w_tick_nxt  = 1'b1;
          w_presc_nxt = '0;
        end else begin
          w_presc_nxt = r_presc + 1'b1;
        end
      end
      ST_SET: begin
        w_min_nxt  = w_rise[1] | w_rpt_min;
        w_hour_nxt = w_rise[2] | w_rpt_hour;
        w_clr_nxt  = w_rise[3];
        if (w_rise[3]) w_presc_nxt = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pCLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= ST_RUN;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_deb_cnt  <= '0;
      r_hist     <= '0;
      r_sw_db    <= '0;
      r_sw_db_d  <= '0;
      r_presc    <= '0;
      r_sec_tick <= 1'b0;
      r_inc_min  <= 1'b0;
      r_inc_hour <= 1'b0;
      r_sec_clr  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sync1    <= TSW;
      r_sync2    <= r_sync1;
      r_deb_cnt  <= r_deb_cnt + 1'b1;
      if (w_samp) r_hist <= w_hist_nxt;
      r_sw_db    <= w_db_nxt;
      r_sw_db_d  <= r_sw_db[3:0];
      r_presc    <= w_presc_nxt;
      r_sec_tick <= w_tick_nxt;
      r_inc_min  <= w_min_nxt;
      r_inc_hour <= w_hour_nxt;
      r_sec_clr  <= w_clr_nxt;
    end
  end

  assign sec_tick = r_sec_tick;
  assign inc_min  = r_inc_min;
  assign inc_hour = r_inc_hour;
  assign sec_clr  = r_sec_clr;
  assign set_mode = (r_state == ST_SET);
  assign sw_db    = r_sw_db;

endmodule

// File: tb/tb_tsw_time_ctrl.sv
// Testbench for tsw_time_ctrl (default parameters). Expected sec_tick
// cycles and expected key strobes are queued as stimulus is applied and
// consumed by a monitor when the DUT produces them.
module tb_tsw_time_ctrl;

  logic       pCLK = 1'b0;
  logic       nRST;
  logic [7:0] TSW;
  logic       sec_tick;
  logic       inc_min;
  logic       inc_hour;
  logic       sec_clr;
  logic       set_mode;
  logic [7:0] sw_db;

  tsw_time_ctrl dut (
    .pCLK     (pCLK),
    .nRST     (nRST),
    .TSW      (TSW),
    .sec_tick (sec_tick),
    .inc_min  (inc_min),
    .inc_hour (inc_hour),
    .sec_clr  (sec_clr),
    .set_mode (set_mode),
    .sw_db    (sw_db)
  );

  always #5 pCLK = ~pCLK;

  // Clocked cycles since reset release; at the negedge after edge n it reads n.
  int cyc;
  always @(posedge pCLK or negedge nRST) begin
    if (!nRST) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_vec = 0;
  int n_err = 0;
  int tick_q[$];
  int key_q[$];
  bit tick_track = 0;
  bit arm_tick   = 0;
  bit exp_set    = 0;
  bit key_free   = 0;
  bit prev_set   = 0;
  int cnt_min    = 0;
  int cnt_hour   = 0;
  int cnt_clr    = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic pop_key(input int kind);
    int e;
    e = (key_q.size() != 0) ? key_q.pop_front() : 0;
    check_val("strobe_kind", kind, e);
  endtask

  task automatic monitor();
    int e;
    forever begin
      @(negedge pCLK);
      if (nRST) begin
        if (prev_set && !set_mode && arm_tick) begin
          tick_q.push_back(cyc + 1024);
          arm_tick   = 0;
          tick_track = 1;
        end
        prev_set = set_mode;
        if (tick_track) begin
          if (sec_tick) begin
            e = (tick_q.size() != 0) ? tick_q.pop_front() : 0;
            check_val("sec_tick_cycle", cyc, e);
          end
        end else if (exp_set) begin
          check_val("tick_in_set", sec_tick, 0);
        end
        if (inc_min) begin
          cnt_min++;
          if (!key_free) pop_key(1);
        end
        if (inc_hour) begin
          cnt_hour++;
          if (!key_free) pop_key(2);
        end
        if (sec_clr) begin
          cnt_clr++;
          if (!key_free) pop_key(3);
        end
      end else begin
        prev_set = 0;
      end
    end
  endtask

  task automatic press(input int b, input int hold);
    TSW[b] = 1'b1;
    repeat (hold) @(negedge pCLK);
    TSW[b] = 1'b0;
    repeat (80) @(negedge pCLK);
  endtask

  initial begin
    int n;
    int t;
    int base_min;
    int base_hour;
    int base_clr;

    TSW  = '0;
    nRST = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge pCLK);
    check_val("rst_set_mode", set_mode, 0);
    check_val("rst_sw_db", sw_db, 0);
    check_val("rst_strobes", {sec_tick, inc_min, inc_hour, sec_clr}, 0);

    // Free-running ticks after release
    tick_q.push_back(1024);
    tick_q.push_back(2048);
    tick_q.push_back(3072);
    tick_track = 1;
    nRST = 1'b1;
    while (cyc < 3100) @(negedge pCLK);
    check_val("ticks_left", tick_q.size(), 0);
    check_val("run_set_mode", set_mode, 0);
    tick_track = 0;

    // Bouncing minute key in RUN: no strobe, level settles
    for (int i = 0; i < 5; i++) begin
      TSW[1] = ~TSW[1];
      if (i < 4) repeat (8) @(negedge pCLK);
    end
    n = 0;
    while (!sw_db[1] && n < 60) begin
      @(negedge pCLK);
      n++;
    end
    check_val("sw_db1_settled", sw_db[1], 1);
    check_val("db_latency_le_51", (n <= 51) ? 1 : 0, 1);
    TSW[1] = 1'b0;
    repeat (80) @(negedge pCLK);
    check_val("sw_db1_released", sw_db[1], 0);

    // Enter SET, 3 minute and 2 hour presses
    press(0, 80);
    exp_set = 1;
    check_val("enter_set", set_mode, 1);
    base_min  = cnt_min;
    base_hour = cnt_hour;
    for (int i = 0; i < 3; i++) begin
      key_q.push_back(1);
      press(1, 80);
    end
    for (int i = 0; i < 2; i++) begin
      key_q.push_back(2);
      press(2, 80);
    end
    check_val("keys_left_a", key_q.size(), 0);
    check_val("inc_min_count", cnt_min - base_min, 3);
    check_val("inc_hour_count", cnt_hour - base_hour, 2);
    check_val("still_set", set_mode, 1);

    // Seconds clear in SET, then back to RUN: first tick 1024 cycles later
    base_clr = cnt_clr;
    key_q.push_back(3);
    press(3, 80);
    check_val("sec_clr_count", cnt_clr - base_clr, 1);
    arm_tick = 1;
    exp_set  = 0;
    press(0, 80);
    check_val("leave_set", set_mode, 0);
    t = 0;
    while ((!tick_track || tick_q.size() != 0) && t < 1500) begin
      @(negedge pCLK);
      t++;
    end
    check_val("first_tick_after_run", (tick_track && tick_q.size() == 0) ? 1 : 0, 1);
    tick_track = 0;
    check_val("keys_left_b", key_q.size(), 0);

    // Hold hour key for 1000 sample periods in SET
    press(0, 80);
    exp_set = 1;
    check_val("enter_set_again", set_mode, 1);
    key_free  = 1;
    base_hour = cnt_hour;
    TSW[2] = 1'b1;
    repeat (16000) @(negedge pCLK);
    TSW[2] = 1'b0;
    repeat (80) @(negedge pCLK);
    key_free = 0;
    n = cnt_hour - base_hour;
`ifdef TSW_AUTOREPEAT_EN
    check_val("hold_hour_repeats", (n >= 122 && n <= 124) ? 1 : 0, 1);
`else
    check_val("hold_hour_once", n, 1);
`endif

    // Asynchronous reset in the middle of a minute-key press
    TSW[1] = 1'b1;
    repeat (12) @(negedge pCLK);
    @(posedge pCLK);
    #3;
    nRST    = 1'b0;
    exp_set = 0;
    #1;
    check_val("async_rst_set_mode", set_mode, 0);
    check_val("async_rst_sw_db", sw_db, 0);
    check_val("async_rst_strobes", {sec_tick, inc_min, inc_hour, sec_clr}, 0);
    TSW[1] = 1'b0;
    repeat (5) @(negedge pCLK);
    nRST = 1'b1;
    repeat (100) @(negedge pCLK);
    check_val("post_rst_sw_db", sw_db, 0);
    check_val("post_rst_set_mode", set_mode, 0);
    check_val("keys_left_c", key_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tsw_time_ctrl.md
# tsw_time_ctrl

Front-end control stage for the digital clock. It synchronises and debounces the eight TSW toggle/push switches and runs a run/set mode state machine. It generates the one-second tick that drives the seconds counter, plus single-cycle minute-increment, hour-increment and seconds-clear strobes. All outputs are synchronous to pCLK, and the downstream counter chain consumes them in place of the free-running divider bit.

## Interface
- TICK_DIV, 1024: pCLK cycles per sec_tick; ≥2.
- DEB_SH, 4: debounce sample period = 2^DEB_SH pCLK cycles.
- REPEAT_DLY, 32: sample periods a held increment key waits before the first auto-repeat.
- REPEAT_PER, 8: sample periods between subsequent auto-repeats.
- pCLK  in  1  clock; all logic on posedge.
- nRST  in  1  asynchronous active-low reset.
- TSW  in  8  raw switches, active-high, asynchronous to pCLK.
- sec_tick  out  1  one-cycle pulse every TICK_DIV cycles in RUN.
- inc_min  out  1  one-cycle minute-increment strobe.
- inc_hour  out  1  one-cycle hour-increment strobe.
- sec_clr  out  1  one-cycle seconds-clear strobe.
- set_mode  out  1  1 = SET state.
- sw_db  out  8  debounced switch levels.

## Operation
- Sync: each TSW bit passes through a 2-flop synchroniser.
- Debounce:
  - A shared counter of width DEB_SH emits a sample strobe when it wraps.
  - On each strobe, a per-bit 3-deep shift register samples its bit.
  - sw_db[i] changes only when all 3 samples agree and differ from the current sw_db[i].
- Edge detect: rise[i] = sw_db[i] & ~sw_db_d[i], where sw_db_d is sw_db delayed 1 cycle.
- Key map:
  - TSW[0]: mode toggle.
  - TSW[1]: minute increment.
  - TSW[2]: hour increment.
  - TSW[3]: seconds clear.
  - TSW[7:4]: appear on sw_db only.
- FSM states: RUN (reset state) and SET.
  - rise[0] toggles between RUN and SET.
  - No other transitions.
- RUN:
  - The prescaler counts 0..TICK_DIV-1.
  - sec_tick = 1 in the cycle the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - rise[1..3] are ignored.
- SET:
  - The prescaler holds its value and sec_tick = 0.
  - rise[1] → inc_min, rise[2] → inc_hour, rise[3] → sec_clr and prescaler := 0.
- Simultaneous events:
  - Strobes are gated by the state registered before the current cycle. A key press in the same cycle as the RUN→SET toggle produces no strobe; a press in the same cycle as SET→RUN does.
  - inc_min, inc_hour and sec_clr may assert in the same cycle.
  - Leaving SET resumes the prescaler from its held value.
- Widths: the prescaler is clog2(TICK_DIV) bits and the repeat counter is 8 bits. Comparisons are unsigned; no overflow is possible.

## Timing
- Reset: every output, the synchroniser, debounce history, prescaler and repeat counter are 0; state = RUN.
  - The assertion takes effect immediately.
  - The first sec_tick after release occurs in cycle TICK_DIV (counting the first clocked cycle after release as 1).
- Switch-to-strobe latency: 2 sync cycles + up to 3 sample periods + 1 edge-detect cycle. Worst case is 3·2^DEB_SH + 3 cycles.
- A glitch shorter than 2 sample periods never changes sw_db.
- Every strobe is exactly 1 cycle wide, with at most one strobe per key per debounced press (auto-repeat excepted).
- Reset asserted mid-debounce or mid-repeat discards the partial state; no strobe is emitted on release.

## Configuration
- TSW_AUTOREPEAT_EN defined:
  - In SET, while sw_db[1] or sw_db[2] stays high, the repeat counter advances per sample strobe.
  - At REPEAT_DLY it issues an extra strobe, then another every REPEAT_PER samples.
  - The counter is cleared on release, on a state change, or if both keys are held. When both are held, each key still gives only its initial edge strobe.
- Undefined: the repeat counter is removed and exactly one strobe is produced per press.

## Test plan
- Reset release, TSW=0, default parameters → sec_tick at cycles 1024, 2048, 3072; no other strobes; set_mode=0.
- TSW[1] bounces (5 toggles spaced 8 cycles), then holds high, in RUN → no inc_min; sw_db[1]=1 within 51 cycles of the final edge.
- Press TSW[0], then TSW[1] ×3, then TSW[2] ×2 → set_mode=1; exactly 3 inc_min and 2 inc_hour pulses; sec_tick stays 0.
- In SET with prescaler=500, press TSW[3], then TSW[0] → one sec_clr; first sec_tick 1024 cycles after the RUN transition.
- With TSW_AUTOREPEAT_EN, in SET hold TSW[2] for 1000 sample periods → inc_hour count = 1 + 1 + floor((1000−32)/8) ±1; undefined macro → exactly 1.
- Assert nRST mid-press, with TSW[1] high for 1 sample only → all outputs 0 asynchronously; no strobe after release.
